win_overlay: RTL and testbench

Positions the 64x48 "WIN" banner image on the display raster and blends it over the game background. It sits between the display timing generator and the video output. It converts raster coordinates into `pixel_x`/`pixel_y` addresses for the `win_rom` image ROM. It aligns the ROM's registered RGB565 output with the delayed background stream. A frame-synchronous blink/hold state machine controls when the banner is visible.

---
 rtl/win_pkg.sv | 24 ++
 rtl/win_overlay_if.sv | 25 ++
 rtl/win_blink_fsm.sv | 97 +++++++++
 rtl/win_overlay.sv | 102 ++++++++++
 tb/tb_win_overlay.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/win_pkg.sv
// Shared constants and types for the WIN banner overlay.
// Holds the image geometry, the transparent key colour, the blink states and the pipeline stage layout.
package win_pkg;

    localparam int ROM_W  = 64;
    localparam int ROM_H  = 48;
    localparam int ROM_AW = 6;

    localparam logic [15:0] KEY_COLOR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        BLINK,
        HOLD
    } win_state_t;

    // One slot of the delay line that carries the raster stream towards the ROM output.
    typedef struct packed {
        logic        in_win;
        logic        de;
        logic [15:0] rgb;
    } win_pipe_t;

endpackage

// File: rtl/win_overlay_if.sv
// Video and image-ROM bus of the WIN overlay.
// The master side is the raster source, the ROM and the sink; the slave side is the overlay.
interface win_overlay_if #(
    parameter int XY_W = 10
);
    logic [XY_W-1:0] scan_x;
    logic [XY_W-1:0] scan_y;
    logic            scan_de;
    logic [15:0]     bg_rgb;
    logic [5:0]      rom_x;
    logic [5:0]      rom_y;
    logic [15:0]     rom_rgb;
    logic [15:0]     out_rgb;
    logic            out_de;

    modport master (
        output scan_x, scan_y, scan_de, bg_rgb, rom_rgb,
        input  rom_x, rom_y, out_rgb, out_de
    );

    modport slave (
        input  scan_x, scan_y, scan_de, bg_rgb, rom_rgb,
        output rom_x, rom_y, out_rgb, out_de
    );
endinterface

// File: rtl/win_blink_fsm.sv
// Frame-synchronous blink/hold controller for the WIN banner.
// Every state or counter change is gated by frame_start, so visibility only ever changes during blanking.
module win_blink_fsm
    import win_pkg::*;
#(
    parameter int BLINK_FRAMES  = 30,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic show_win,
    input  logic frame_start,
    output logic visible,
    output logic active
);

    localparam int FC_W = $clog2(BLINK_FRAMES + 1);
    localparam int TC_W = $clog2(BLINK_TOGGLES + 1);

    win_state_t      state_reg, state_next;
    logic [FC_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic [TC_W-1:0] toggle_cnt_reg, toggle_cnt_next;
    logic            visible_reg, visible_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            frame_cnt_reg  <= '0;
            toggle_cnt_reg <= '0;
            visible_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            frame_cnt_reg  <= frame_cnt_next;
            toggle_cnt_reg <= toggle_cnt_next;
            visible_reg    <= visible_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        frame_cnt_next  = frame_cnt_reg;
        toggle_cnt_next = toggle_cnt_reg;
        visible_next    = visible_reg;
        if (frame_start) begin
            unique case (state_reg)
                IDLE: begin
                    if (show_win) begin
                        state_next      = BLINK;
                        frame_cnt_next  = '0;
                        toggle_cnt_next = '0;
                        visible_next    = 1'b1;
                    end
                end
                BLINK: begin
                    // Dropping show_win outranks the blink update of the same frame.
                    if (!show_win) begin
                        state_next      = IDLE;
                        frame_cnt_next  = '0;
                        toggle_cnt_next = '0;
                        visible_next    = 1'b0;
                    end else if (frame_cnt_reg == FC_W'(BLINK_FRAMES - 1)) begin
                        frame_cnt_next  = '0;
                        toggle_cnt_next = toggle_cnt_reg + TC_W'(1);
                        if (TC_W'(toggle_cnt_reg + TC_W'(1)) == TC_W'(BLINK_TOGGLES)) begin
                            state_next   = HOLD;
                            visible_next = 1'b1;
                        end else begin
                            visible_next = ~visible_reg;
                        end
                    end else begin
                        frame_cnt_next = frame_cnt_reg + FC_W'(1);
                    end
                end
                HOLD: begin
                    if (!show_win) begin
                        state_next      = IDLE;
                        frame_cnt_next  = '0;
                        toggle_cnt_next = '0;
                        visible_next    = 1'b0;
                    end else begin
                        visible_next = 1'b1;
                    end
                end
                default: begin
                    state_next      = IDLE;
                    frame_cnt_next  = '0;
                    toggle_cnt_next = '0;
                    visible_next    = 1'b0;
                end
            endcase
        end
    end

    assign visible = visible_reg;
    assign active  = (state_reg != IDLE);

endmodule

// File: rtl/win_overlay.sv
// Places the upscaled 64x48 WIN image on the raster and keys it over the background.
// Stage 1 registers the ROM address, stage 2 meets the ROM data and stage 3 registers the composite.
module win_overlay
    import win_pkg::*;
#(
    parameter int ORIGIN_X      = 96,
    parameter int ORIGIN_Y      = 96,
    parameter int SCALE_SHIFT   = 2,
    parameter int BLINK_FRAMES  = 30,
    parameter int BLINK_TOGGLES = 6,
    parameter int XY_W          = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        show_win,
    input  logic        frame_start,
    win_overlay_if.slave vif,
    output logic        active
);

    // One extra bit so the window end never wraps.
    localparam int X_END = ORIGIN_X + (ROM_W << SCALE_SHIFT);
    localparam int Y_END = ORIGIN_Y + (ROM_H << SCALE_SHIFT);
    localparam logic [XY_W:0] X_LO = (XY_W + 1)'(ORIGIN_X);
    localparam logic [XY_W:0] X_HI = (XY_W + 1)'(X_END);
    localparam logic [XY_W:0] Y_LO = (XY_W + 1)'(ORIGIN_Y);
    localparam logic [XY_W:0] Y_HI = (XY_W + 1)'(Y_END);

    logic [XY_W:0]       x_ext, y_ext;
    logic                in_win;
    logic [ROM_AW-1:0]   rom_x_next, rom_y_next;
    logic [ROM_AW-1:0]   rom_x_reg, rom_y_reg;
    win_pipe_t           dly_reg [0:1];
    logic [15:0]         out_rgb_next, out_rgb_reg;
    logic                out_de_reg;
    logic                visible;

    assign x_ext = {1'b0, vif.scan_x};
    assign y_ext = {1'b0, vif.scan_y};

    assign in_win = vif.scan_de
                 && (x_ext >= X_LO) && (x_ext < X_HI)
                 && (y_ext >= Y_LO) && (y_ext < Y_HI);

    assign rom_x_next = in_win ? ROM_AW'((x_ext - X_LO) >> SCALE_SHIFT) : '0;
    assign rom_y_next = in_win ? ROM_AW'((y_ext - Y_LO) >> SCALE_SHIFT) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_x_reg <= '0;
            rom_y_reg <= '0;
            for (int i = 0; i < 2; i++) begin
                dly_reg[i] <= '0;
            end
        end else begin
            rom_x_reg  <= rom_x_next;
            rom_y_reg  <= rom_y_next;
            dly_reg[0] <= '{in_win: in_win, de: vif.scan_de, rgb: vif.bg_rgb};
            dly_reg[1] <= dly_reg[0];
        end
    end

    // dly_reg[1] lines up with the ROM word fetched from the stage-1 address.
    always_comb begin
        out_rgb_next = '0;
        if (dly_reg[1].de) begin
            if (dly_reg[1].in_win && visible && (vif.rom_rgb != KEY_COLOR)) begin
                out_rgb_next = vif.rom_rgb;
            end else begin
                out_rgb_next = dly_reg[1].rgb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_rgb_reg <= '0;
            out_de_reg  <= 1'b0;
        end else begin
            out_rgb_reg <= out_rgb_next;
            out_de_reg  <= dly_reg[1].de;
        end
    end

    win_blink_fsm #(
        .BLINK_FRAMES  (BLINK_FRAMES),
        .BLINK_TOGGLES (BLINK_TOGGLES)
    ) u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .show_win    (show_win),
        .frame_start (frame_start),
        .visible     (visible),
        .active      (active)
    );

    assign vif.rom_x   = rom_x_reg;
    assign vif.rom_y   = rom_y_reg;
    assign vif.out_rgb = out_rgb_reg;
    assign vif.out_de  = out_de_reg;

endmodule

// File: tb/tb_win_overlay.sv
// Randomized bench for win_overlay: pixel stream scoreboard against an arithmetic window/blink model.
module tb_win_overlay;

    localparam int OX = 96;
    localparam int OY = 96;
    localparam int SS = 2;
    localparam int BF = 30;
    localparam int BT = 6;

    typedef struct {
        logic [5:0]  rx;
        logic [5:0]  ry;
        logic [15:0] exp_out;
        logic        exp_de;
    } pix_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic show_win = 1'b0;
    logic frame_start = 1'b0;
    logic active;

    int checks = 0;
    int errors = 0;

    logic [15:0] rom_mem [0:4095];
    pix_t        hist[$];
    int          act_k = 0;
    logic        exp_vis = 1'b0;

    win_overlay_if #(.XY_W(10)) vif ();

    win_overlay #(
        .ORIGIN_X      (OX),
        .ORIGIN_Y      (OY),
        .SCALE_SHIFT   (SS),
        .BLINK_FRAMES  (BF),
        .BLINK_TOGGLES (BT),
        .XY_W          (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .show_win    (show_win),
        .frame_start (frame_start),
        .vif         (vif),
        .active      (active)
    );

    always #5 clk = ~clk;

    // External image ROM with one registered read cycle.
    always @(posedge clk) begin
        vif.rom_rgb <= rom_mem[int'(vif.rom_y) * 64 + int'(vif.rom_x)];
    end

    function automatic logic model_vis(input int k);
        int t;
        if (k == 0) return 1'b0;
        t = (k - 1) / BF;
        if (t >= BT) return 1'b1;
        return (t % 2) == 0;
    endfunction

    task automatic step_pixel(input int x, input int y, input logic de, input logic [15:0] bg);
        pix_t p;
        bit inw;
        int ax, ay;
        logic [15:0] img;
        @(negedge clk);
        if (hist.size() >= 1) begin
            checks++;
            if (vif.rom_x !== hist[$].rx || vif.rom_y !== hist[$].ry) begin
                errors++;
                $display("FAIL rom_addr got (%0d,%0d) expected (%0d,%0d)",
                         vif.rom_x, vif.rom_y, hist[$].rx, hist[$].ry);
            end
        end
        if (hist.size() >= 3) begin
            checks++;
            if (vif.out_rgb !== hist[$-2].exp_out || vif.out_de !== hist[$-2].exp_de) begin
                errors++;
                $display("FAIL pixel_out got rgb=%h de=%b expected rgb=%h de=%b",
                         vif.out_rgb, vif.out_de, hist[$-2].exp_out, hist[$-2].exp_de);
            end
        end
        inw = de && x >= OX && x < OX + (64 << SS) && y >= OY && y < OY + (48 << SS);
        ax  = inw ? (x - OX) / (1 << SS) : 0;
        ay  = inw ? (y - OY) / (1 << SS) : 0;
        img = rom_mem[ay * 64 + ax];
        p.rx = 6'(ax);
        p.ry = 6'(ay);
        p.exp_de = de;
        if (!de) p.exp_out = 16'h0000;
        else if (inw && exp_vis && img != 16'h0000) p.exp_out = img;
        else p.exp_out = bg;
        vif.scan_x  = 10'(x);
        vif.scan_y  = 10'(y);
        vif.scan_de = de;
        vif.bg_rgb  = bg;
        hist.push_back(p);
        if (hist.size() > 3) void'(hist.pop_front());
    endtask

    task automatic idle_pixels(input int n);
        for (int i = 0; i < n; i++) step_pixel(0, 0, 1'b0, 16'h0000);
    endtask

    task automatic probe_visible();
        step_pixel(OX, OY, 1'b1, 16'h5A5A);
        idle_pixels(3);
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        vif.scan_de = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        hist.delete();
        act_k   = show_win ? act_k + 1 : 0;
        exp_vis = model_vis(act_k);
        checks++;
        if (active !== (act_k > 0)) begin
            errors++;
            $display("FAIL active after frame %0d got %b expected %b", act_k, active, act_k > 0);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (vif.rom_x !== 6'd0 || vif.rom_y !== 6'd0 || vif.out_rgb !== 16'h0 ||
            vif.out_de !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rom=(%0d,%0d) rgb=%h de=%b act=%b expected all 0",
                     vif.rom_x, vif.rom_y, vif.out_rgb, vif.out_de, active);
        end
        rst_n = 1'b1;
        hist.delete();
    endtask

    task automatic test_addr_map();
        int tbl [8][4] = '{
            '{96, 96, 0, 0}, '{100, 100, 1, 1}, '{351, 287, 63, 47}, '{352, 96, 0, 0},
            '{95, 96, 0, 0}, '{96, 95, 0, 0}, '{96, 288, 0, 0}, '{351, 96, 63, 0}
        };
        for (int i = 0; i < 8; i++) begin
            step_pixel(tbl[i][0], tbl[i][1], 1'b1, 16'(16'h1000 + i));
            @(posedge clk);
            #1;
            checks++;
            if (vif.rom_x !== 6'(tbl[i][2]) || vif.rom_y !== 6'(tbl[i][3])) begin
                errors++;
                $display("FAIL addr_map (%0d,%0d) got (%0d,%0d) expected (%0d,%0d)",
                         tbl[i][0], tbl[i][1], vif.rom_x, vif.rom_y, tbl[i][2], tbl[i][3]);
            end
        end
        idle_pixels(3);
    endtask

    task automatic test_random_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            step_pixel($urandom_range(370, 80), $urandom_range(300, 80),
                       ($urandom_range(9, 0) != 0), 16'($urandom));
        end
        idle_pixels(3);
    endtask

    task automatic test_transparency();
        logic [15:0] keep0, keep1;
        keep0 = rom_mem[0];
        keep1 = rom_mem[65];
        rom_mem[0]  = 16'h0000;
        rom_mem[65] = 16'h07E0;
        step_pixel(96, 96, 1'b1, 16'h1234);
        idle_pixels(2);
        @(posedge clk);
        #1;
        checks++;
        if (vif.out_rgb !== 16'h1234) begin
            errors++;
            $display("FAIL transparent_key got %h expected 1234", vif.out_rgb);
        end
        step_pixel(100, 100, 1'b1, 16'h1234);
        idle_pixels(2);
        @(posedge clk);
        #1;
        checks++;
        if (vif.out_rgb !== 16'h07E0) begin
            errors++;
            $display("FAIL opaque_pixel got %h expected 07e0", vif.out_rgb);
        end
        idle_pixels(1);
        rom_mem[0]  = keep0;
        rom_mem[65] = keep1;
        hist.delete();
    endtask

    task automatic test_de_low();
        step_pixel(150, 150, 1'b1, 16'h1111);
        step_pixel(151, 150, 1'b0, 16'hBEEF);
        step_pixel(152, 150, 1'b1, 16'h2222);
        step_pixel(153, 150, 1'b1, 16'h3333);
        @(posedge clk);
        #1;
        checks++;
        if (vif.out_de !== 1'b0 || vif.out_rgb !== 16'h0000) begin
            errors++;
            $display("FAIL de_low got de=%b rgb=%h expected de=0 rgb=0000", vif.out_de, vif.out_rgb);
        end
        idle_pixels(3);
    endtask

    task automatic test_blink();
        show_win = 1'b0;
        pulse_frame();
        show_win = 1'b1;
        for (int k = 0; k < 1 + BF * BT; k++) begin
            pulse_frame();
            probe_visible();
        end
        for (int k = 0; k < 3; k++) begin
            pulse_frame();
            probe_visible();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) step_pixel(120 + i, 130, 1'b1, 16'hC0DE);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (vif.rom_x !== 6'd0 || vif.rom_y !== 6'd0 || vif.out_rgb !== 16'h0 ||
            vif.out_de !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got rom=(%0d,%0d) rgb=%h de=%b act=%b expected all 0",
                     vif.rom_x, vif.rom_y, vif.out_rgb, vif.out_de, active);
        end
        show_win = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        hist.delete();
        act_k   = 0;
        exp_vis = 1'b0;
        probe_visible();
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_active got %b expected 0", active);
        end
    endtask

    task automatic test_drop_show();
        show_win = 1'b1;
        for (int k = 0; k < 10; k++) pulse_frame();
        probe_visible();
        @(negedge clk);
        show_win = 1'b0;
        hist.delete();
        for (int i = 0; i < 3; i++) probe_visible();
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL drop_early_active got %b expected 1", active);
        end
        pulse_frame();
        probe_visible();
    endtask

    initial begin
        vif.scan_x  = '0;
        vif.scan_y  = '0;
        vif.scan_de = 1'b0;
        vif.bg_rgb  = '0;
        vif.rom_rgb = '0;
        for (int i = 0; i < 4096; i++) begin
            rom_mem[i] = ($urandom_range(3, 0) == 0) ? 16'h0000 : 16'($urandom);
        end
        rom_mem[0] = 16'hF800;

        test_reset();
        test_addr_map();
        test_random_pixels(200);
        show_win = 1'b1;
        pulse_frame();
        test_transparency();
        test_random_pixels(300);
        test_de_low();
        test_blink();
        test_async_reset();
        test_drop_show();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
